// File: rtl/fb_pkg.sv
// Frame-buffer arbiter shared types: geometry, write-queue entry, FSM states.
// Widths here size the memory port and the write-queue entry.
package fb_pkg;

   localparam int FB_W      = 640;
   localparam int FB_H      = 480;
   localparam int FB_PIXELS = FB_W * FB_H;
   localparam int IDX_W     = 2;
   localparam int ADDR_W    = 19;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [IDX_W-1:0]  data;
   } fb_wr_t;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Pixel-write queue: registered level, head visible combinationally, pops take effect next edge.
// Caller must not push when full or pop when empty; push+pop together keeps the level.
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic             push,
   input  fb_wr_t           din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output fb_wr_t           head
);

   fb_wr_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: only entries behind a valid pointer are ever read.
   always_ff @(posedge vga_clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   assign head  = r_mem[r_rd_ptr];
   assign full  = (r_level == LVL_W'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one frame-buffer port: scanout reads own it during active video, queued writes drain otherwise.
// Scanout index appears 1 cycle after hcount/vcount; writer is stalled by wr_ready only when the queue is full.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter  int SCREEN_WIDTH  = FB_W,
   parameter  int SCREEN_HEIGHT = FB_H,
   parameter  int FIFO_DEPTH    = 4,
   localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [IDX_W-1:0]  wr_data,
   output logic              wr_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [IDX_W-1:0]  mem_wdata,
   input  logic [IDX_W-1:0]  mem_rdata,
   output logic [IDX_W-1:0]  pix_idx,
   output logic              pix_valid,
   output logic [LVL_W-1:0]  fifo_level,
   output logic [7:0]        wr_drop_cnt
);

   fb_state_e         r_state;
   fb_state_e         w_state_nxt;
   logic              w_active;
   logic              w_read;
   logic              w_pop;
   logic              w_push;
   logic              w_in_range;
   logic              w_full;
   logic              w_empty;
   fb_wr_t            w_head;
   fb_wr_t            w_din;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] r_hold_addr;
   logic [IDX_W-1:0]  r_hold_wdata;
   logic              r_rd_flag;
   logic [7:0]        r_drop_cnt;

   assign w_active  = (hcount < 10'(SCREEN_WIDTH)) && (vcount < 10'(SCREEN_HEIGHT));
   assign w_rd_addr = ADDR_W'(vcount) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(hcount);

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_SYNC;
      else          r_state <= w_state_nxt;
   end

   // The origin pixel is already read in the cycle that leaves ST_SYNC.
   always_comb begin
      w_state_nxt = r_state;
      w_read      = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (hcount == '0 && vcount == '0) begin
               w_state_nxt = ST_RUN;
               w_read      = w_active;
            end
         end
         ST_RUN:  w_read = w_active;
         default: w_state_nxt = ST_SYNC;
      endcase
   end

   assign w_pop = !w_read && !w_empty;

   always_comb begin
      mem_we    = w_pop;
      mem_addr  = r_hold_addr;
      mem_wdata = r_hold_wdata;
      if (w_read) begin
         mem_addr = w_rd_addr;
      end else if (w_pop) begin
         mem_addr  = w_head.addr;
         mem_wdata = w_head.data;
      end
   end

   assign wr_ready   = !w_full;
   assign w_in_range = (wr_addr < ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT));
   assign w_push     = wr_valid && wr_ready && w_in_range;
   assign w_din      = '{addr: wr_addr, data: wr_data};

   fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .push    (w_push),
      .din     (w_din),
      .pop     (w_pop),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level),
      .head    (w_head)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_flag    <= 1'b0;
         r_hold_addr  <= '0;
         r_hold_wdata <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_rd_flag    <= w_read;
         r_hold_addr  <= mem_addr;
         r_hold_wdata <= mem_wdata;
         if (wr_valid && wr_ready && !w_in_range && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign pix_valid   = r_rd_flag;
   assign pix_idx     = r_rd_flag ? mem_rdata : '0;
   assign wr_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural frame-buffer memory and a window scoreboard.
module tb_fb_port_arbiter;

   localparam int NPIX = 640 * 480;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        wr_valid;
   logic [18:0] wr_addr;
   logic [1:0]  wr_data;
   logic        wr_ready;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [1:0]  mem_wdata;
   logic [1:0]  mem_rdata;
   logic [1:0]  pix_idx;
   logic        pix_valid;
   logic [2:0]  fifo_level;
   logic [7:0]  wr_drop_cnt;

   int   errors;
   int   checks;
   logic tb_run;
   logic [1:0] mem [NPIX];
   logic [1:0] sb  [128];

   always #5 vga_clk = ~vga_clk;

   fb_port_arbiter dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .hcount      (hcount),
      .vcount      (vcount),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pix_idx     (pix_idx),
      .pix_valid   (pix_valid),
      .fifo_level  (fifo_level),
      .wr_drop_cnt (wr_drop_cnt)
   );

   // Single-port synchronous RAM: read data registered, write-first not needed.
   always @(posedge vga_clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge vga_clk) begin
      if (tb_run && reset_n && hcount < 10'd640 && vcount < 10'd480) begin
         checks++;
         assert (mem_we === 1'b0) else begin
            errors++;
            $error("FAIL we_in_active observed=%0d expected=0 h=%0d v=%0d", mem_we, hcount, vcount);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge vga_clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int r, c, d, n;
      errors = 0; checks = 0; tb_run = 1'b0;
      for (int i = 0; i < NPIX; i++) mem[i] = 2'd0;
      mem[1285] = 2'd2;
      reset_n = 1'b0; hcount = 10'd700; vcount = 10'd500;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();

      // 1: queue 3 entries mid-frame, then reset
      hcount = 10'd0; vcount = 10'd0; tb_run = 1'b1;
      cyc();
      hcount = 10'd100; vcount = 10'd10; wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = 19'(5000 + i); wr_data = 2'(i + 1);
         cyc();
      end
      wr_valid = 1'b0;
      at_neg();
      chk("t1_level_before_rst", 32'(fifo_level), 3);
      #1 reset_n = 1'b0; tb_run = 1'b0;
      #1;
      chk("t1_rst_pix_idx",   32'(pix_idx), 0);
      chk("t1_rst_pix_valid", 32'(pix_valid), 0);
      chk("t1_rst_mem_we",    32'(mem_we), 0);
      chk("t1_rst_mem_addr",  32'(mem_addr), 0);
      chk("t1_rst_mem_wdata", 32'(mem_wdata), 0);
      chk("t1_rst_level",     32'(fifo_level), 0);
      chk("t1_rst_wr_ready",  32'(wr_ready), 1);
      chk("t1_rst_drop",      32'(wr_drop_cnt), 0);
      cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("t1_sync_pix_valid", 32'(pix_valid), 0);
         chk("t1_sync_mem_we",    32'(mem_we), 0);
         cyc();
      end
      hcount = 10'd0; vcount = 10'd0; tb_run = 1'b1;
      at_neg();
      chk("t1_origin_pix_valid", 32'(pix_valid), 0);
      chk("t1_origin_mem_addr",  32'(mem_addr), 0);
      cyc();
      hcount = 10'd1;
      at_neg();
      chk("t1_first_pix_valid", 32'(pix_valid), 1);
      chk("t1_first_pix_idx",   32'(pix_idx), 0);
      cyc();

      // 2: scanout read of (5,2)
      hcount = 10'd5; vcount = 10'd2;
      at_neg();
      chk("t2_mem_addr", 32'(mem_addr), 1285);
      chk("t2_mem_we",   32'(mem_we), 0);
      cyc();
      hcount = 10'd640;
      at_neg();
      chk("t2_pix_idx",   32'(pix_idx), 2);
      chk("t2_pix_valid", 32'(pix_valid), 1);
      cyc();
      at_neg();
      chk("t2_blank_pix_valid", 32'(pix_valid), 0);
      chk("t2_blank_pix_idx",   32'(pix_idx), 0);
      cyc();

      // 3: three writes in active video drain at line end
      hcount = 10'd100; vcount = 10'd10; wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = 19'(2000 + i); wr_data = 2'(i + 1);
         at_neg();
         chk("t3_push_ready", 32'(wr_ready), 1);
         cyc();
      end
      wr_valid = 1'b0;
      at_neg();
      chk("t3_level_queued", 32'(fifo_level), 3);
      cyc();
      hcount = 10'd640;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("t3_drain_we",    32'(mem_we), 1);
         chk("t3_drain_addr",  32'(mem_addr), 2000 + i);
         chk("t3_drain_data",  32'(mem_wdata), i + 1);
         chk("t3_drain_level", 32'(fifo_level), 3 - i);
         cyc();
         hcount = hcount + 10'd1;
      end
      at_neg();
      chk("t3_idle_we",    32'(mem_we), 0);
      chk("t3_idle_level", 32'(fifo_level), 0);
      chk("t3_hold_addr",  32'(mem_addr), 2002);
      chk("t3_hold_data",  32'(mem_wdata), 3);
      cyc();

      // 4: overfill during active video; fifth write waits for a freed slot
      hcount = 10'd200; vcount = 10'd20; wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = 19'(3000 + i); wr_data = 2'(3 - i);
         at_neg();
         chk("t4_push_ready", 32'(wr_ready), 1);
         cyc();
      end
      wr_addr = 19'd3004; wr_data = 2'd2;
      at_neg();
      chk("t4_full_ready", 32'(wr_ready), 0);
      chk("t4_full_level", 32'(fifo_level), 4);
      cyc();
      at_neg();
      chk("t4_held_ready", 32'(wr_ready), 0);
      cyc();
      hcount = 10'd640;
      at_neg();
      chk("t4_blank1_ready", 32'(wr_ready), 0);
      chk("t4_blank1_we",    32'(mem_we), 1);
      chk("t4_blank1_addr",  32'(mem_addr), 3000);
      chk("t4_blank1_level", 32'(fifo_level), 4);
      cyc();
      at_neg();
      chk("t4_blank2_ready", 32'(wr_ready), 1);
      chk("t4_blank2_addr",  32'(mem_addr), 3001);
      chk("t4_blank2_level", 32'(fifo_level), 3);
      cyc();
      wr_valid = 1'b0;
      at_neg();
      chk("t4_pushpop_level", 32'(fifo_level), 3);
      chk("t4_blank3_addr",   32'(mem_addr), 3002);
      chk("t4_blank3_data",   32'(mem_wdata), 1);
      cyc();
      at_neg();
      chk("t4_blank4_addr",  32'(mem_addr), 3003);
      chk("t4_blank4_level", 32'(fifo_level), 2);
      cyc();
      at_neg();
      chk("t4_fifth_addr",  32'(mem_addr), 3004);
      chk("t4_fifth_data",  32'(mem_wdata), 2);
      chk("t4_fifth_level", 32'(fifo_level), 1);
      cyc();
      at_neg();
      chk("t4_empty_we",    32'(mem_we), 0);
      chk("t4_empty_level", 32'(fifo_level), 0);
      cyc();

      // 5: out-of-range writes are dropped and counted
      hcount = 10'd640; vcount = 10'd20; wr_valid = 1'b1;
      wr_addr = 19'd307200; wr_data = 2'd3;
      at_neg();
      chk("t5_oob_ready", 32'(wr_ready), 1);
      chk("t5_oob_we",    32'(mem_we), 0);
      chk("t5_drop0",     32'(wr_drop_cnt), 0);
      cyc();
      wr_addr = 19'd307199; wr_data = 2'd1;
      at_neg();
      chk("t5_drop1",       32'(wr_drop_cnt), 1);
      chk("t5_oob_level",   32'(fifo_level), 0);
      chk("t5_oob_no_we",   32'(mem_we), 0);
      cyc();
      wr_valid = 1'b0;
      at_neg();
      chk("t5_last_we",   32'(mem_we), 1);
      chk("t5_last_addr", 32'(mem_addr), 307199);
      chk("t5_last_drop", 32'(wr_drop_cnt), 1);
      cyc();
      wr_valid = 1'b1;
      for (int i = 0; i < 253; i++) begin
         wr_addr = 19'(307200 + i);
         cyc();
      end
      wr_valid = 1'b0;
      at_neg();
      chk("t5_drop254", 32'(wr_drop_cnt), 254);
      cyc();
      wr_valid = 1'b1;
      for (int i = 0; i < 47; i++) begin
         wr_addr = 19'(307300 + i);
         cyc();
      end
      wr_valid = 1'b0;
      at_neg();
      chk("t5_drop_sat",  32'(wr_drop_cnt), 255);
      chk("t5_sat_level", 32'(fifo_level), 0);
      cyc();

      // 6: random writes into a 32x4 window, then scan it back
      for (int k = 0; k < 128; k++) sb[k] = (k == 2 * 32 + 5) ? 2'd2 : 2'd0;
      for (int i = 0; i < 40; i++) begin
         if ((i % 8) < 3) begin hcount = 10'd300; vcount = 10'd100; end
         else             begin hcount = 10'd700; vcount = 10'd10;  end
         r = int'($urandom_range(3, 0));
         c = int'($urandom_range(31, 0));
         d = int'($urandom_range(3, 0));
         wr_valid = 1'b1; wr_addr = 19'(r * 640 + c); wr_data = 2'(d);
         at_neg();
         if (wr_ready === 1'b1) sb[r * 32 + c] = 2'(d);
         cyc();
      end
      wr_valid = 1'b0; hcount = 10'd700; vcount = 10'd10;
      n = 0;
      while (fifo_level != 3'd0 && n < 20) begin
         cyc();
         n++;
      end
      chk("t6_drain_level", 32'(fifo_level), 0);
      cyc();
      for (int k = 0; k < 128; k++) begin
         hcount = 10'(k % 32); vcount = 10'(k / 32);
         at_neg();
         if (k > 0) begin
            chk("t6_pix_idx",   32'(pix_idx), 32'(sb[k - 1]));
            chk("t6_pix_valid", 32'(pix_valid), 1);
         end
         cyc();
      end
      hcount = 10'd700;
      at_neg();
      chk("t6_pix_idx_last", 32'(pix_idx), 32'(sb[127]));
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
